// File: rtl/issue_scoreboard.sv
// Issue scoreboard: tracks in-flight GPR writers, stalls ID on RAW/WAW/limit hazards, drain handshake.
// Optional stall watchdog enabled by defining ISSUE_SCOREBOARD_WATCHDOG_EN.
module issue_scoreboard #(
  parameter int REG_ADDR_LEN    = 5,
  parameter int NUM_REGS        = 32,
  parameter int MAX_OUTSTANDING = 4,
  parameter int CNT_W           = 3,
  parameter int WATCHDOG_LIMIT  = 255
) (
  input  logic                    i_sys_clk,
  input  logic                    i_sys_rst,
  input  logic                    i_id_valid,
  output logic                    o_id_ready,
  input  logic [REG_ADDR_LEN-1:0] i_src_addr1,
  input  logic [REG_ADDR_LEN-1:0] i_src_addr2,
  input  logic                    i_src2_used,
  input  logic                    i_writeback_en,
  input  logic [REG_ADDR_LEN-1:0] i_dest_addr,
  input  logic                    i_flush,
  input  logic                    i_wb_valid,
  input  logic [REG_ADDR_LEN-1:0] i_wb_addr,
  input  logic                    i_drain_req,
  output logic                    o_drain_done,
  output logic                    o_issue,
  output logic                    o_stall,
  output logic [NUM_REGS-1:0]     o_pending,
  output logic [CNT_W-1:0]        o_outstanding,
  output logic                    o_wb_err,
  output logic                    o_watchdog
);

  typedef enum logic [1:0] {ST_RUN = 2'd0, ST_DRAIN = 2'd1, ST_DONE = 2'd2} state_e;

  state_e                state_q, state_d;
  logic [NUM_REGS-1:0]   pending_q, pending_d;
  logic [CNT_W-1:0]      outstanding_q, outstanding_d;
  logic                  wb_err_q, wb_err_d;

  logic [NUM_REGS-1:0]   wb_mask, set_mask, pend_bp;
  logic                  raw1, raw2, waw, lim;
  logic                  wb_clr, wb_bad, do_set;
  logic                  id_ready, issue, stall;

  always_comb begin
    wb_mask  = '0;
    set_mask = '0;
    if (i_wb_valid) wb_mask[i_wb_addr] = 1'b1;
    // A register retiring this cycle no longer blocks the instruction in ID.
    pend_bp = pending_q & ~wb_mask;

    raw1 = (i_src_addr1 != '0) && pend_bp[i_src_addr1];
    raw2 = i_src2_used && (i_src_addr2 != '0) && pend_bp[i_src_addr2];
    waw  = i_writeback_en && (i_dest_addr != '0) && pend_bp[i_dest_addr];

    wb_clr = i_wb_valid && (i_wb_addr != '0) && pending_q[i_wb_addr];
    wb_bad = i_wb_valid && (i_wb_addr != '0) && !pending_q[i_wb_addr];
    lim    = i_writeback_en && (i_dest_addr != '0) &&
             (outstanding_q == CNT_W'(MAX_OUTSTANDING)) && !wb_clr;

    id_ready = i_sys_rst && (state_q == ST_RUN) && !i_drain_req && !i_flush &&
               !(raw1 || raw2 || waw || lim);
    issue    = i_id_valid && id_ready;
    stall    = i_sys_rst && i_id_valid && !id_ready && !i_flush;

    do_set = issue && i_writeback_en && (i_dest_addr != '0);
    if (do_set) set_mask[i_dest_addr] = 1'b1;

    // Set is applied after clear so a same-register retire/reissue stays pending.
    pending_d     = (pending_q & ~wb_mask) | set_mask;
    outstanding_d = outstanding_q + CNT_W'(do_set) - CNT_W'(wb_clr);
    wb_err_d      = wb_err_q | wb_bad;

    state_d = state_q;
    case (state_q)
      ST_RUN:   if (i_drain_req) state_d = ST_DRAIN;
      ST_DRAIN: begin
        if (!i_drain_req)                state_d = ST_RUN;
        else if (outstanding_d == '0)    state_d = ST_DONE;
      end
      ST_DONE:  if (!i_drain_req) state_d = ST_RUN;
      default:  state_d = ST_RUN;
    endcase
  end

  always_ff @(posedge i_sys_clk) begin
    if (!i_sys_rst) begin
      state_q       <= ST_RUN;
      pending_q     <= '0;
      outstanding_q <= '0;
      wb_err_q      <= 1'b0;
    end else begin
      state_q       <= state_d;
      pending_q     <= pending_d;
      outstanding_q <= outstanding_d;
      wb_err_q      <= wb_err_d;
    end
  end

  assign o_id_ready    = id_ready;
  assign o_issue       = issue;
  assign o_stall       = stall;
  assign o_drain_done  = i_sys_rst && (state_q == ST_DONE);
  assign o_pending     = pending_q;
  assign o_outstanding = outstanding_q;
  assign o_wb_err      = wb_err_q;

`ifdef ISSUE_SCOREBOARD_WATCHDOG_EN
  localparam int WD_W = $clog2(WATCHDOG_LIMIT + 1);

  logic [WD_W-1:0] wd_cnt_q, wd_cnt_d;
  logic            watchdog_q, watchdog_d;

  always_comb begin
    wd_cnt_d = wd_cnt_q;
    if (issue)
      wd_cnt_d = '0;
    else if ((stall || state_q == ST_DRAIN) && (wd_cnt_q != WD_W'(WATCHDOG_LIMIT)))
      wd_cnt_d = wd_cnt_q + WD_W'(1);
    watchdog_d = watchdog_q | (wd_cnt_d == WD_W'(WATCHDOG_LIMIT));
  end

  always_ff @(posedge i_sys_clk) begin
    if (!i_sys_rst) begin
      wd_cnt_q   <= '0;
      watchdog_q <= 1'b0;
    end else begin
      wd_cnt_q   <= wd_cnt_d;
      watchdog_q <= watchdog_d;
    end
  end

  assign o_watchdog = watchdog_q;
`else
  logic unused_wd;
  assign unused_wd  = ^WATCHDOG_LIMIT;
  assign o_watchdog = 1'b0;
`endif

endmodule
